// File: rtl/wdecoder.sv
// ---------------------------------------------------------------------------
// wdecoder
//
// Receive-side deserializer for the weight/sum byte stream coming out of the
// column-block weight encoder's byte serializer. Each rising edge of the
// byte strobe takes one byte. Five bytes, most significant first, form one
// record {weight, sum}. The record is presented together with the index of
// its column block within the current line.
//
// The block also recovers framing after stream gaps. A partial record that
// stalls for too long is thrown away. A long quiet period between records
// marks the start of a new line, so the block index restarts at 0.
//
// Ports
//   pclk       in   1   clock, all logic on the rising edge
//   rst        in   1   synchronous active-high reset
//   ready      in   1   byte strobe; a byte is taken on its rising edge only
//   din        in   8   byte data, valid while ready is high
//   out_valid  out  1   record available on weight/sum/blkIdx
//   out_ack    in   1   consumer takes the record when high with out_valid
//   weight     out  24  decoded weight field (high bits of the record)
//   sum        out  16  decoded sum field (low bits of the record)
//   blkIdx     out  8   column block index within the line, wraps 255 -> 0
//   overrun    out  1   sticky: a completed record was dropped (holding full)
//   syncErr    out  1   one-cycle pulse when a stalled partial is discarded
// ---------------------------------------------------------------------------
module wdecoder #(
    parameter int sumSize    = 16,
    parameter int weightSize = 24,
    parameter int byteCount  = 5,
    parameter int gapLimit   = 64,
    parameter int lineGap    = 1024
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  ready,
    input  logic [7:0]            din,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic [weightSize-1:0] weight,
    output logic [sumSize-1:0]    sum,
    output logic [7:0]            blkIdx,
    output logic                  overrun,
    output logic                  syncErr
);

    localparam int recWidth  = sumSize + weightSize;
    localparam int cntWidth  = $clog2(byteCount + 1);
    localparam int gapWidth  = $clog2(gapLimit + 1);
    localparam int idleWidth = $clog2(lineGap + 1);

    localparam logic [cntWidth-1:0]  lastByte = cntWidth'(byteCount - 1);
    localparam logic [gapWidth-1:0]  gapLast  = gapWidth'(gapLimit - 1);
    localparam logic [idleWidth-1:0] idleLast = idleWidth'(lineGap - 1);
    localparam logic [idleWidth-1:0] idleMax  = idleWidth'(lineGap);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                state;
    logic                  ready_q;
    logic                  byteEvt;
    logic [cntWidth-1:0]   byteCnt;
    logic [gapWidth-1:0]   gapCnt;
    logic [idleWidth-1:0]  idleCnt;
    logic [7:0]            nextIdx;

    // Only the first byteCount-1 bytes are ever stored. The final byte is
    // merged combinationally when the record completes, so the assembly
    // register never needs to hold a full record.
    logic [recWidth-9:0]   asmReg;
    logic [recWidth-1:0]   asmNext;

    logic                  recordDone;
    logic                  lineRestart;
    logic                  holdFree;

    // Byte event is the rising edge of the strobe. A level held high for
    // several cycles yields exactly one event.
    assign byteEvt     = ready & ~ready_q;
    assign asmNext     = {asmReg, din};
    assign recordDone  = (state == COLLECT) && byteEvt && (byteCnt == lastByte);
    // Fires on the cycle the idle counter steps onto lineGap.
    assign lineRestart = (state == IDLE) && !byteEvt && (idleCnt == idleLast);
    // The holding register may take a new record if it is empty or is being
    // emptied by the consumer in this very cycle.
    assign holdFree    = !out_valid || out_ack;

    // Previous-strobe register used for rising-edge detection of ready.
    always_ff @(posedge pclk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready;
        end
    end

    // Framing FSM. It collects bytes into the assembly register and counts
    // the bytes of the current record. It also watches for a stall in the
    // middle of a record. A byte arriving on the same cycle the stall limit
    // would be hit wins over the timeout, because the byte branch is tested
    // first.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state   <= IDLE;
            byteCnt <= '0;
            asmReg  <= '0;
            gapCnt  <= '0;
            syncErr <= 1'b0;
        end else begin
            syncErr <= 1'b0;
            case (state)
                IDLE: begin
                    gapCnt <= '0;
                    if (byteEvt) begin
                        asmReg  <= (recWidth - 8)'(din);
                        byteCnt <= cntWidth'(1);
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (byteEvt) begin
                        asmReg <= asmNext[recWidth-9:0];
                        gapCnt <= '0;
                        if (byteCnt == lastByte) begin
                            byteCnt <= '0;
                            state   <= IDLE;
                        end else begin
                            byteCnt <= byteCnt + 1'b1;
                        end
                    end else if (gapCnt == gapLast) begin
                        state   <= IDLE;
                        asmReg  <= '0;
                        byteCnt <= '0;
                        gapCnt  <= '0;
                        syncErr <= 1'b1;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Idle counter measures the quiet time between records. It only runs
    // while waiting for the first byte of a record, and it saturates so a
    // very long pause cannot wrap it back into range.
    always_ff @(posedge pclk) begin
        if (rst) begin
            idleCnt <= '0;
        end else if (state != IDLE || byteEvt) begin
            idleCnt <= '0;
        end else if (idleCnt != idleMax) begin
            idleCnt <= idleCnt + 1'b1;
        end
    end

    // Next block index. It advances for every completed record, delivered or
    // dropped, so that indices stay aligned with column position. A
    // discarded partial record does not advance it. A long gap between
    // records starts a new line at index 0.
    always_ff @(posedge pclk) begin
        if (rst) begin
            nextIdx <= '0;
        end else if (recordDone) begin
            nextIdx <= nextIdx + 8'd1;
        end else if (lineRestart) begin
            nextIdx <= '0;
        end
    end

    // Output holding register with valid/ack handshake. A completed record
    // loads if the register is free. Otherwise the record is lost and the
    // sticky overrun flag records the loss. The held outputs do not change
    // while the consumer is stalling.
    always_ff @(posedge pclk) begin
        if (rst) begin
            out_valid <= 1'b0;
            weight    <= '0;
            sum       <= '0;
            blkIdx    <= '0;
            overrun   <= 1'b0;
        end else if (recordDone && holdFree) begin
            weight    <= asmNext[recWidth-1 -: weightSize];
            sum       <= asmNext[sumSize-1:0];
            blkIdx    <= nextIdx;
            out_valid <= 1'b1;
        end else begin
            if (recordDone) begin
                overrun <= 1'b1;
            end
            if (out_valid && out_ack) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wdecoder.sv
// ---------------------------------------------------------------------------
// tb_wdecoder
//
// Self-checking bench for wdecoder. The expected records are kept in a
// queue, one entry per record that should be delivered. Each entry holds
// the weight, sum and block index the decoder should produce.
//
// The block index is computed at record level. It is the count of completed
// records since reset or since the last long pause, taken mod 256. A
// monitor compares every cycle in which a record is presented against the
// head of the queue, and pops the head when the record is acknowledged.
// ---------------------------------------------------------------------------
module tb_wdecoder;

    logic        pclk = 1'b0;
    logic        rst;
    logic        ready;
    logic [7:0]  din;
    logic        out_valid;
    logic        out_ack;
    logic [23:0] weight;
    logic [15:0] sum;
    logic [7:0]  blkIdx;
    logic        overrun;
    logic        syncErr;

    int          checkCnt = 0;
    int          passCnt  = 0;

    logic [47:0] expQ[$];
    logic [7:0]  modelIdx;
    logic        expOverrun;
    int          expSync;
    int          syncSeen;
    int          ackMode;

    always #5 pclk = ~pclk;

    wdecoder #(
        .sumSize   (16),
        .weightSize(24),
        .byteCount (5),
        .gapLimit  (64),
        .lineGap   (1024)
    ) dut (
        .pclk     (pclk),
        .rst      (rst),
        .ready    (ready),
        .din      (din),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .weight   (weight),
        .sum      (sum),
        .blkIdx   (blkIdx),
        .overrun  (overrun),
        .syncErr  (syncErr)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCnt++;
        if (actual === expected) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // One byte on the link: strobe high for hi cycles, then low for lo cycles.
    task automatic applyStimulus(input logic [7:0] b, input int hi, input int lo);
        din   = b;
        ready = 1'b1;
        waitCycles(hi);
        ready = 1'b0;
        din   = 8'($urandom);
        waitCycles(lo);
    endtask

    // Sends a full record MSB first and updates the record-level model.
    task automatic sendRecord(input logic [23:0] w, input logic [15:0] s,
                              input int hi, input int lo, input bit dropIt);
        logic [39:0] rec;
        rec = {w, s};
        if (dropIt) begin
            expOverrun = 1'b1;
        end else begin
            expQ.push_back({rec, modelIdx});
        end
        modelIdx = modelIdx + 8'd1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(rec[39 - 8*i -: 8], hi, lo);
        end
    endtask

    task automatic setAck(input int mode);
        ackMode = mode;
        if (mode == 0) out_ack = 1'b0;
        if (mode == 1) out_ack = 1'b1;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < limit) begin
            waitCycles(1);
            n++;
        end
        checkOutput("drain", 64'(expQ.size()), 64'd0);
    endtask

    task automatic checkpoint(input string tag);
        drain(600);
        checkOutput({tag, "_overrun"}, 64'(overrun), 64'(expOverrun));
        checkOutput({tag, "_syncErrs"}, 64'(syncSeen), 64'(expSync));
    endtask

    task automatic resetDut();
        rst   = 1'b1;
        ready = 1'b0;
        din   = 8'h00;
        waitCycles(3);
        expQ.delete();
        modelIdx   = 8'd0;
        expOverrun = 1'b0;
        expSync    = 0;
        syncSeen   = 0;
        rst        = 1'b0;
        checkOutput("rst_valid",   64'(out_valid), 64'd0);
        checkOutput("rst_weight",  64'(weight),    64'd0);
        checkOutput("rst_sum",     64'(sum),       64'd0);
        checkOutput("rst_blkIdx",  64'(blkIdx),    64'd0);
        checkOutput("rst_overrun", 64'(overrun),   64'd0);
        checkOutput("rst_syncErr", 64'(syncErr),   64'd0);
    endtask

    // Consumer side: the acknowledge is driven just after each rising edge,
    // either fixed or random.
    initial begin
        out_ack = 1'b1;
        forever begin
            @(posedge pclk);
            #1;
            case (ackMode)
                0:       out_ack = 1'b0;
                1:       out_ack = 1'b1;
                default: out_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor, sampled on the falling edge. Every presented record must
    // match the head of the queue. This also proves that held data stays
    // stable and that no extra record or lingering valid appears.
    always @(negedge pclk) begin
        if (!rst) begin
            if (syncErr) syncSeen++;
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousValid", 64'(out_valid), 64'd0);
                end else begin
                    checkOutput("record", 64'({weight, sum, blkIdx}), 64'(expQ[0]));
                    if (out_ack) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [23:0] w;
        logic [15:0] s;
        rst        = 1'b1;
        ready      = 1'b0;
        din        = 8'h00;
        ackMode    = 1;
        modelIdx   = 8'd0;
        expOverrun = 1'b0;
        expSync    = 0;
        syncSeen   = 0;
        waitCycles(2);
        resetDut();

        $display("[TB] basic record, 4-cycle byte spacing");
        sendRecord(24'h123456, 16'hABCD, 1, 3, 1'b0);
        checkpoint("basic");

        $display("[TB] strobe held 3 cycles per byte");
        sendRecord(24'h123456, 16'hABCD, 3, 2, 1'b0);
        checkpoint("wideStrobe");

        $display("[TB] partial record then 64 idle cycles");
        applyStimulus(8'h12, 1, 3);
        applyStimulus(8'h34, 1, 64);
        expSync++;
        sendRecord(24'h123456, 16'hABCD, 1, 3, 1'b0);
        checkpoint("gapTimeout");

        $display("[TB] byte spacing of 63 idle cycles stays in frame");
        sendRecord(24'hC0FFEE, 16'h5A5A, 1, 63, 1'b0);
        checkpoint("gapEdge");

        $display("[TB] stalled consumer, second record dropped");
        resetDut();
        setAck(0);
        sendRecord(24'h111111, 16'h2222, 1, 1, 1'b0);
        waitCycles(5);
        sendRecord(24'h333333, 16'h4444, 1, 1, 1'b1);
        waitCycles(5);
        checkOutput("held_overrun", 64'(overrun), 64'd1);
        checkOutput("held_valid", 64'(out_valid), 64'd1);
        setAck(1);
        sendRecord(24'h555555, 16'h6666, 1, 3, 1'b0);
        checkpoint("overrun");

        $display("[TB] line restart after long idle");
        waitCycles(1100);
        modelIdx = 8'd0;
        for (int i = 0; i < 3; i++) begin
            w = 24'($urandom);
            s = 16'($urandom);
            sendRecord(w, s, 1, 3, 1'b0);
        end
        waitCycles(1000);
        sendRecord(24'hABCDEF, 16'h0123, 1, 3, 1'b0);
        waitCycles(1030);
        modelIdx = 8'd0;
        sendRecord(24'hFEDCBA, 16'h3210, 1, 3, 1'b0);
        checkpoint("lineRestart");

        $display("[TB] reset in the middle of a record");
        applyStimulus(8'hDE, 1, 3);
        applyStimulus(8'hAD, 1, 3);
        applyStimulus(8'hBE, 1, 3);
        resetDut();
        sendRecord(24'h000001, 16'h0002, 1, 3, 1'b0);
        checkpoint("midReset");

        $display("[TB] random records, consumer always ready");
        setAck(1);
        repeat (300) begin
            w = 24'($urandom);
            s = 16'($urandom);
            sendRecord(w, s, $urandom_range(1, 3), $urandom_range(1, 3), 1'b0);
            waitCycles($urandom_range(0, 20));
        end
        checkpoint("randFast");

        $display("[TB] random records, random consumer stalls");
        setAck(2);
        repeat (40) begin
            w = 24'($urandom);
            s = 16'($urandom);
            sendRecord(w, s, $urandom_range(1, 3), $urandom_range(1, 3), 1'b0);
            drain(500);
            waitCycles($urandom_range(0, 10));
        end
        setAck(1);
        checkpoint("randAck");

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/wdecoder.md
# wdecoder

Receive-side deserializer for the weight/sum byte stream produced by the column-block weight encoder. It detects each byte strobe, reassembles 5-byte records MSB-first into `{weight[23:0], sum[15:0]}`, and presents each record with a block index on a valid/ack handshake. It also recovers framing after stream gaps and flags dropped records. It sits on the capture or host side of the link, downstream of the encoder's byte serializer.

## Interface
- `sumSize`, 16, width of the sum field (low bits of a record).
- `weightSize`, 24, width of the weight field (high bits of a record).
- `byteCount`, 5, bytes per record; must equal (sumSize+weightSize)/8.
- `gapLimit`, 64, idle cycles mid-record before the partial record is discarded.
- `lineGap`, 1024, idle cycles between records before the block index restarts at 0.
- `pclk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ready`  in  1  byte strobe from the serializer; a byte is taken on its rising edge (level may last several cycles).
- `din`  in  8  byte data, valid whenever `ready` is high.
- `out_valid`  out  1  record available on `weight`/`sum`/`blkIdx`.
- `out_ack`  in  1  consumer accepts the record when high together with `out_valid`.
- `weight`  out  24  decoded weight field.
- `sum`  out  16  decoded sum field.
- `blkIdx`  out  8  index of the column block within the current line, wrapping at 255 to 0.
- `overrun`  out  1  sticky; a completed record was dropped because the holding register was full.
- `syncErr`  out  1  one-cycle pulse when a partial record is discarded by the gap timeout.

## Operation
- Reset values: `out_valid`=0, `weight`=0, `sum`=0, `blkIdx`=0, `overrun`=0, `syncErr`=0. Byte counter, gap counter and idle counter are 0. The previous-strobe register is 0.
- Strobe detect: `ready_q` registers `ready`. A byte event is `ready & ~ready_q`. `din` is sampled in that same cycle.
- The FSM has two states.
  - IDLE (byte counter = 0): a byte event loads byte 0 and moves to COLLECT with counter = 1.
  - COLLECT: each byte event shifts the 40-bit assembly register left 8 and inserts `din` in the low byte, then increments the counter. On the event that brings the count to `byteCount`, the record completes, the counter returns to 0 and the FSM goes to IDLE.
- Byte order: the first byte received is bits [39:32]. The result is weight = asm[39:16], sum = asm[15:0].
- Delivery on record completion:
  - If the holding register is free (`out_valid`=0, or `out_valid & out_ack` in the same cycle), load `weight`/`sum`, set `out_valid`=1 and load `blkIdx` from the next-index counter, then increment that counter mod 256.
  - Otherwise, drop the record, set `overrun`=1 and still increment the next-index counter.
- `out_valid` clears on `out_valid & out_ack` unless a new record loads in the same cycle, in which case it stays 1 with the new data. Outputs hold stable while `out_valid`=1 and `out_ack`=0.
- Gap timeout: in COLLECT, the gap counter increments on each cycle without a byte event and clears on a byte event. When it reaches `gapLimit`:
  - go to IDLE, clear the assembly register and counter, and pulse `syncErr` for one cycle;
  - the next-index counter is unchanged.
- Line restart: in IDLE, the idle counter increments on each cycle without a byte event and saturates at `lineGap`. On reaching `lineGap` the next-index counter resets to 0. A byte event clears the idle counter.
- Simultaneous events: a byte event in the same cycle the gap counter would reach `gapLimit` is treated as a byte, with no timeout.
- Reset mid-record returns everything to the reset values; partial data is discarded.

## Timing
- Latency: `out_valid` rises one cycle after the cycle in which the final byte's rising strobe is sampled.
- Minimum strobe spacing is 2 cycles (high, low). Back-to-back records at this rate are accepted with no drop if `out_ack` is held high.
- `syncErr` is high exactly during the cycle after the gap counter reaches `gapLimit`.
- `overrun` asserts one cycle after the dropping completion and stays high until `rst`.

## Test plan
- Reset, then strobe bytes 0x12, 0x34, 0x56, 0xAB, 0xCD at 4-cycle spacing with `out_ack`=1 -> one record: `weight`=0x123456, `sum`=0xABCD, `blkIdx`=0, `out_valid` high for 1 cycle.
- Hold `ready` high for 3 cycles per byte, same bytes -> exactly one record; no duplicate bytes taken.
- Send 2 bytes, then idle 64 cycles, then the full 5-byte record above -> `syncErr` pulses once; next record decodes correctly as 0x123456/0xABCD.
- `out_ack`=0, send two complete records -> first record held stable; second dropped; `overrun`=1; a third record after one ack carries `blkIdx`=2.
- Three records, idle 1024 cycles, then one record -> `blkIdx` 0, 1, 2, then 0.
- Assert `rst` after byte 3 of a record, then send a fresh record 0x000001/0x0002 -> `weight`=0x000001, `sum`=0x0002, `blkIdx`=0, `overrun`=0.
